// File: rtl/fetch_unit_pkg.sv
// Shared core definitions: datapath width, fetch-state encoding, default
// reset PC and the canonical NOP used as the "no instruction" filler.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } fetch_state_t;

    // Instruction fetches are always word aligned: clear the two low bits.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, requests words from instruction
// memory over valid/ready, and holds the returned word for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
// target raises fetch_misaligned for one cycle and parks fetch until the
// next redirect; without it the low target bits are silently cleared.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_misaligned
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] inst_reg, inst_next;
    logic [XLEN-1:0] inst_pc_reg, inst_pc_next;
    logic            inst_valid_reg, inst_valid_next;
    logic            drop_reg, drop_next;
    logic            redirect_live;
    logic [XLEN-1:0] redirect_pc;

    // Redirects are meaningless before the first fetch has been set up.
    assign redirect_live = redirect_valid && (state_reg != ST_BOOT);
    assign redirect_pc   = align_word(redirect_target);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic park_reg, park_next;
    logic misaligned_reg, misaligned_next;

    // Trap bookkeeping: one-cycle flag plus the "parked until redirected" bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            park_reg       <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            park_reg       <= park_next;
            misaligned_reg <= misaligned_next;
        end
    end

    assign fetch_misaligned = misaligned_reg;
`else
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_target[1:0];
    assign fetch_misaligned   = 1'b0;
`endif

    // Fetch state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_BOOT;
            pc_reg         <= RESET_PC;
            inst_reg       <= NOP_INST;
            inst_pc_reg    <= RESET_PC;
            inst_valid_reg <= 1'b0;
            drop_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
            inst_valid_reg <= inst_valid_next;
            drop_reg       <= drop_next;
        end
    end

    // Next-state logic: normal fetch flow first, then redirect overrides it.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;
        inst_valid_next = inst_valid_reg;
        drop_next       = drop_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
        park_next       = park_reg;
        misaligned_next = 1'b0;
`endif

        case (state_reg)
            ST_BOOT: state_next = ST_REQ;
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_next       = imem_rsp_data;
                    inst_pc_next    = pc_reg;
                    inst_valid_next = 1'b1;
                    state_next      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_valid_reg && inst_ready) begin
                    pc_next         = pc_reg + 32'd4;
                    inst_valid_next = 1'b0;
                    inst_next       = NOP_INST;
                    state_next      = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The response owed to a squashed request is thrown away.
                if (imem_rsp_valid && drop_reg) begin
                    drop_next  = 1'b0;
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_BOOT;
        endcase

        if (redirect_live) begin
            pc_next         = redirect_pc;
            inst_pc_next    = inst_pc_reg;
            inst_valid_next = 1'b0;
            inst_next       = NOP_INST;
            if (state_reg == ST_DRAIN) begin
                // Still owed a response: keep draining, only the PC moves.
            end else if ((state_reg == ST_REQ && imem_req_ready) ||
                         (state_reg == ST_WAIT && !imem_rsp_valid)) begin
                drop_next  = 1'b1;
                state_next = ST_DRAIN;
            end else begin
                state_next = ST_REQ;
            end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_live) begin
            misaligned_next = (redirect_target[1:0] != 2'b00);
            park_next       = misaligned_next;
        end
        // A parked fetch idles in HOLD with nothing valid until redirected.
        if (park_next && state_next == ST_REQ) begin
            state_next = ST_HOLD;
        end
`endif
    end

    assign imem_req_valid = (state_reg == ST_REQ);
    assign imem_addr      = pc_reg;
    assign inst_valid     = inst_valid_reg;
    assign inst           = inst_reg;
    assign inst_pc        = inst_pc_reg;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end for the RV32IM core.
- Holds the PC, issues requests to instruction memory over a valid/ready handshake, and latches the returned word.
- Presents instruction + PC to decode/immediate generation; accepts redirects from branch/jump resolution.
- Multi-cycle memory latency is tolerated; the core stalls while inst_valid is low.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, word driven on inst when no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  32  request address, word aligned
imem_rsp_valid  in  1  response data valid (one per accepted request, in order)
imem_rsp_data  in  32  fetched instruction word
inst_valid  out  1  inst/inst_pc hold a valid instruction
inst_ready  in  1  downstream consumes instruction this cycle
inst  out  32  instruction to decoder / immediate generator
inst_pc  out  32  address of inst
redirect_valid  in  1  control-flow change (taken branch, jal, jalr)
redirect_target  in  32  new PC
fetch_misaligned  out  1  see Optional Feature

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, state=BOOT, imem_req_valid=0, inst_valid=0, inst=NOP_INST, inst_pc=RESET_PC, fetch_misaligned=0, drop flag cleared.
- States: BOOT, REQ, WAIT, HOLD, DRAIN. All outputs come from registers or the state; there is no combinational path from inputs to outputs.
- BOOT: moves to REQ on the first clock after reset deasserts.
- REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready, go to WAIT. The request stays stable until accepted.
- WAIT: on imem_rsp_valid, latch inst<=rsp_data, inst_pc<=pc, set inst_valid=1, go to HOLD.
  - Minimum latency: request accepted in cycle N, response in N+1, inst_valid in N+2.
- HOLD: inst and inst_pc are held stable while inst_valid=1. On inst_valid&&inst_ready: pc<=pc+4 (wraps mod 2^32), inst_valid<=0, inst<=NOP_INST, go to REQ.
- Redirect (any state except BOOT): pc<=redirect_target with bits [1:0] forced 0, inst_valid<=0, inst<=NOP_INST, then:
  - REQ with request already accepted this cycle, or WAIT: set drop flag and go to DRAIN.
  - Otherwise: go to REQ.
- DRAIN: the next imem_rsp_valid is discarded; the drop flag clears and the state goes to REQ. A redirect during DRAIN only updates pc; the state stays DRAIN.
- Simultaneous redirect and inst handshake: redirect wins, pc=target (not pc+4).
- Simultaneous redirect and rsp_valid in WAIT: the response is discarded and the state goes to REQ directly.
- rsp_valid outside WAIT/DRAIN is ignored.
- Reset mid-transaction: all state is cleared. Memory-side cleanup of outstanding responses is the memory's responsibility (both share rst_n).

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with target[1:0]!=0 still loads the aligned pc and sets fetch_misaligned=1 for exactly one cycle (registered, cycle after redirect). No fetch is issued for that target; the state goes to REQ only after the next redirect. The trap handler supplies that redirect.
- Undefined: low bits are silently forced to 0 and fetch_misaligned is tied 0.

Decomposition:
- Shared core package holds:
  - the fetch-state enum (BOOT, REQ, WAIT, HOLD, DRAIN)
  - the NOP_INST constant
  - the default RESET_PC
  - the XLEN=32 width constant, also used by the immediate generator and ALU
- No sub-module is needed; a single module of roughly 150–250 lines.

Test Plan:
- Reset release, memory always ready, 1-cycle response, inst_ready=1 → addresses 0x0, 0x4, 0x8 are issued; inst_valid rises 2 cycles after each accept; inst_pc matches each address.
- inst_ready held low for 5 cycles in HOLD with inst=0x00500093 → inst/inst_pc stay stable, no new request, pc stays at 0x0; on release the next request goes to 0x4.
- Redirect to 0x100 while in WAIT, response arrives 3 cycles later with 0xDEADBEEF → the word is dropped and never appears on inst; the next request goes to 0x100.
- Redirect to 0x200 in the same cycle as an inst handshake at pc 0x40 → the next request is 0x200, not 0x44.
- pc=0xFFFF_FFFC, handshake → the next request wraps to 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 → fetch_misaligned pulses once, pc=0x100, no request until a redirect to 0x80, which fetches 0x80. Without the macro, the same redirect to 0x102 fetches 0x100.
